// File: rtl/axil2cpu_bridge.sv
// AXI4-Lite slave to single-beat cpu_wr/cpu_rd register bus bridge.
// Serialises reads and writes; one transaction outstanding at a time.
module axil2cpu_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int RD_LAT         = 2
) (
  input  logic                        clks,
  input  logic                        reset,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  input  logic [CPU_DATA_WIDTH-1:0]   s_wdata,
  input  logic [CPU_DATA_WIDTH/8-1:0] s_wstrb,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  output logic [1:0]                  s_bresp,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  output logic [CPU_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        cpu_wr,
  output logic                        cpu_rd,
  output logic [CPU_ADDR_WIDTH-1:0]   cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0]   cpu_data_in,
  input  logic [CPU_DATA_WIDTH-1:0]   cpu_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t                    state, state_nxt;
  logic                      last_wr;
  logic                      wr_req, rd_req;
  logic                      grant_wr, grant_rd;
  logic                      strb_full;
  logic [2:0]                lat_cnt;
  logic [CPU_ADDR_WIDTH-1:0] aw_word, ar_word;
  logic                      unused_addr_bits;

  assign wr_req    = s_awvalid && s_wvalid;
  assign rd_req    = s_arvalid;
  assign aw_word   = s_awaddr[CPU_ADDR_WIDTH+1:2];
  assign ar_word   = s_araddr[CPU_ADDR_WIDTH+1:2];
  assign strb_full = &s_wstrb;
  // Byte-lane and high address bits alias onto the same register word.
  assign unused_addr_bits = ^{s_awaddr, s_araddr};

  always_comb begin
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // Contended grant alternates; last_wr resets low so a write wins first.
        if (reset) begin
          if (wr_req && (!rd_req || !last_wr)) grant_wr = 1'b1;
          else if (rd_req)                     grant_rd = 1'b1;
        end
        if (grant_wr)      state_nxt = WR_ISSUE;
        else if (grant_rd) state_nxt = RD_ISSUE;
      end
      WR_ISSUE: state_nxt = WR_RESP;
      WR_RESP:  if (s_bready) state_nxt = IDLE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_cnt == 3'd0) state_nxt = RD_RESP;
      RD_RESP:  if (s_rready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign s_awready = grant_wr;
  assign s_wready  = grant_wr;
  assign s_arready = grant_rd;
  assign s_bvalid  = (state == WR_RESP);
  assign s_rvalid  = (state == RD_RESP);
  assign s_rresp   = 2'b00;

  always_ff @(posedge clks or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_wr     <= 1'b0;
      lat_cnt     <= '0;
      cpu_wr      <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_wr_addr <= '0;
      cpu_data_in <= '0;
      s_bresp     <= '0;
      s_rdata     <= '0;
    end else begin
      state  <= state_nxt;
      cpu_wr <= 1'b0;
      cpu_rd <= 1'b0;
      if (grant_wr) begin
        last_wr     <= 1'b1;
        cpu_wr_addr <= aw_word;
        cpu_data_in <= s_wdata;
        cpu_wr      <= strb_full;
        s_bresp     <= strb_full ? 2'b00 : 2'b10;
      end
      if (grant_rd) begin
        last_wr     <= 1'b0;
        cpu_wr_addr <= ar_word;
        cpu_rd      <= 1'b1;
        lat_cnt     <= LAT_M1;
      end
      // Counter spans RD_LAT cycles after the cpu_rd strobe cycle.
      if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd0) s_rdata <= cpu_data_out;
      end
    end
  end

endmodule

// File: tb/tb_axil2cpu_bridge.sv
// Self-checking bench for axil2cpu_bridge: directed protocol steps plus
// randomized accesses checked against a word-array register model.
module tb_axil2cpu_bridge;

  localparam int RD_LAT = 2;

  logic        clks, reset;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic        cpu_wr, cpu_rd;
  logic [11:0] cpu_wr_addr;
  logic [31:0] cpu_data_in, cpu_data_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] regs  [4096];
  logic [31:0] model [4096];

  axil2cpu_bridge #(
    .AXI_ADDR_WIDTH(32),
    .CPU_ADDR_WIDTH(12),
    .CPU_DATA_WIDTH(32),
    .RD_LAT(RD_LAT)
  ) dut (
    .clks(clks), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wr_addr(cpu_wr_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out)
  );

  initial clks = 1'b0;
  always #5 clks = ~clks;

  // Register block with a registered read mux.
  always @(posedge clks) begin
    if (cpu_wr) regs[cpu_wr_addr] <= cpu_data_in;
    cpu_data_out <= regs[cpu_wr_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clks);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] word_of(input logic [31:0] a);
    return 12'((a / 4) % 4096);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int unsigned bwait);
    int unsigned n;
    logic full;
    n    = 0;
    full = (s == 4'hF);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    #1;
    while (!s_awready && n < 40) begin tick(); #1; n++; end
    chk("wr_accept", 32'(n < 40), 32'd1);
    chk("wr_wready", 32'(s_wready), 32'd1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_cpu_wr_c1", 32'(cpu_wr), 32'(full));
    chk("wr_addr_c1", 32'(cpu_wr_addr), 32'(word_of(a)));
    chk("wr_data_c1", cpu_data_in, d);
    chk("wr_bvalid_c1", 32'(s_bvalid), 32'd0);
    if (full) model[word_of(a)] = d;
    tick();
    chk("wr_cpu_wr_c2", 32'(cpu_wr), 32'd0);
    chk("wr_bvalid_c2", 32'(s_bvalid), 32'd1);
    chk("wr_bresp", 32'(s_bresp), full ? 32'd0 : 32'd2);
    for (int unsigned i = 0; i < bwait; i++) begin
      tick();
      chk("wr_bvalid_hold", 32'(s_bvalid), 32'd1);
      chk("wr_arready_blocked", 32'(s_arready), 32'd0);
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    chk("wr_bvalid_done", 32'(s_bvalid), 32'd0);
    if (s_arvalid) chk("rd_accept_after_b", 32'(s_arready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input int unsigned rwait);
    int unsigned n;
    logic [31:0] exp;
    n   = 0;
    exp = model[word_of(a)];
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b0;
    #1;
    while (!s_arready && n < 40) begin tick(); #1; n++; end
    chk("rd_accept", 32'(n < 40), 32'd1);
    tick();
    s_arvalid = 1'b0;
    chk("rd_cpu_rd_c1", 32'(cpu_rd), 32'd1);
    chk("rd_addr_c1", 32'(cpu_wr_addr), 32'(word_of(a)));
    for (int unsigned k = 2; k <= 1 + RD_LAT; k++) begin
      tick();
      chk("rd_cpu_rd_off", 32'(cpu_rd), 32'd0);
      chk("rd_rvalid_early", 32'(s_rvalid), 32'd0);
    end
    tick();
    chk("rd_rvalid", 32'(s_rvalid), 32'd1);
    chk("rd_rdata", s_rdata, exp);
    chk("rd_rresp", 32'(s_rresp), 32'd0);
    for (int unsigned i = 0; i < rwait; i++) begin
      tick();
      chk("rd_rvalid_hold", 32'(s_rvalid), 32'd1);
      chk("rd_rdata_stable", s_rdata, exp);
      chk("rd_readies_blocked", 32'({s_arready, s_awready}), 32'd0);
    end
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk("rd_rvalid_done", 32'(s_rvalid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cpu"}, {cpu_wr, cpu_rd, 30'(cpu_wr_addr)}, 32'd0);
    chk({tag, "_data_in"}, cpu_data_in, 32'd0);
    chk({tag, "_valids"}, 32'({s_bvalid, s_rvalid, s_awready, s_wready, s_arready}), 32'd0);
    chk({tag, "_resps"}, 32'({s_bresp, s_rresp}), 32'd0);
    chk({tag, "_rdata"}, s_rdata, 32'd0);
  endtask

  initial begin
    int unsigned ng, cyc, aw_seen, ar_seen;
    logic order [4];
    logic [31:0] a;

    for (int i = 0; i < 4096; i++) begin regs[i] = '0; model[i] = '0; end
    regs[0] = 32'h2018_0702; model[0] = 32'h2018_0702;
    regs[6] = 32'hCAFE_0006; model[6] = 32'hCAFE_0006;

    reset = 1'b0;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    s_awaddr = '0; s_wdata = '0; s_wstrb = 4'hF; s_araddr = '0;
    s_bready = 1'b0; s_rready = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    reset = 1'b1;
    tick();

    // Contended arbitration straight after reset: W, R, W, R.
    s_awaddr = 32'h100; s_wdata = 32'hA5A5_0001; s_wstrb = 4'hF; s_araddr = 32'h100;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      #1;
      if (s_awready) begin order[ng] = 1'b1; ng++; model[64] = 32'hA5A5_0001; end
      else if (s_arready) begin order[ng] = 1'b0; ng++; end
      if (s_rvalid) chk("arb_rdata", s_rdata, model[64]);
      tick(); cyc++;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    chk("arb_grants", ng, 32'd4);
    for (int i = 0; i < 4; i++) chk("arb_order", 32'(order[i]), 32'((i % 2) == 0));
    repeat (10) tick();
    s_bready = 1'b0; s_rready = 1'b0;

    // AW without W is never accepted, even once a pending read completes.
    s_awaddr = 32'h40; s_awvalid = 1'b1; s_wvalid = 1'b0;
    s_araddr = 32'h0; s_arvalid = 1'b1; s_rready = 1'b1;
    aw_seen = 0; ar_seen = 0;
    for (int i = 0; i < 8 + RD_LAT; i++) begin
      #1;
      if (s_awready || s_wready) aw_seen++;
      if (s_arready) ar_seen++;
      tick();
      if (ar_seen != 0) s_arvalid = 1'b0;
    end
    s_awvalid = 1'b0; s_rready = 1'b0;
    chk("aw_only_ready", aw_seen, 32'd0);
    chk("aw_only_read_grants", ar_seen, 32'd1);

    do_write(32'h20, 32'h0000_1234, 4'hF, 0);
    do_read(32'h0, 0);
    do_read(32'h20, 1);
    do_write(32'h18, 32'hDEAD_BEEF, 4'h3, 0);
    do_read(32'h18, 0);

    // B held off with a read waiting; the read is granted right after B.
    s_araddr = 32'h20; s_arvalid = 1'b1;
    do_write(32'h24, 32'h5555_AAAA, 4'hF, 5);
    do_read(32'h20, 0);

    // Reset during RD_WAIT drops the read.
    s_araddr = 32'h8; s_arvalid = 1'b1;
    #1;
    tick();
    s_arvalid = 1'b0;
    chk("rst_rd_issue", 32'(cpu_rd), 32'd1);
    tick();
    s_arvalid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (2) tick();
    s_arvalid = 1'b0;
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (s_rvalid) cyc++; end
    chk("mid_reset_no_rvalid", cyc, 32'd0);
    do_read(32'h4, 0);

    // Randomized accesses with aliased addresses.
    for (int t = 0; t < 30; t++) begin
      a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom),
                 $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axil2cpu_bridge.md
Name: axil2cpu_bridge

Overview:
- AXI4-Lite slave that converts host register accesses into the single-beat cpu_wr/cpu_rd register bus consumed by the user-logic register file.
- Sits directly upstream of the register block.
- Serialises reads and writes: one outstanding transaction at a time.
- Holds the word address stable so the register block's registered read mux can be sampled after a fixed latency.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI byte-address width.
- CPU_ADDR_WIDTH, 12, register word-address width.
- CPU_DATA_WIDTH, 32, data width; must equal the AXI data width.
- RD_LAT, 2, cycles from cpu_rd assertion to the cpu_data_out sample; legal range 1..7.

Ports:
- clks  in  1  Sole clock.
- reset  in  1  Asynchronous, active-low reset (one clock clks; reset is asynchronous and active-low).
- s_awvalid  in  1  Write address valid.
- s_awready  out  1  Write address ready.
- s_awaddr  in  AXI_ADDR_WIDTH  Write byte address.
- s_wvalid  in  1  Write data valid.
- s_wready  out  1  Write data ready.
- s_wdata  in  CPU_DATA_WIDTH  Write data.
- s_wstrb  in  CPU_DATA_WIDTH/8  Byte strobes.
- s_bvalid  out  1  Write response valid.
- s_bready  in  1  Write response ready.
- s_bresp  out  2  Write response; 00 OKAY, 10 SLVERR.
- s_arvalid  in  1  Read address valid.
- s_arready  out  1  Read address ready.
- s_araddr  in  AXI_ADDR_WIDTH  Read byte address.
- s_rvalid  out  1  Read data valid.
- s_rready  in  1  Read data ready.
- s_rdata  out  CPU_DATA_WIDTH  Read data.
- s_rresp  out  2  Read response; always 00.
- cpu_wr  out  1  Single-cycle register write strobe.
- cpu_rd  out  1  Single-cycle register read strobe.
- cpu_wr_addr  out  CPU_ADDR_WIDTH  Word address, shared by reads and writes.
- cpu_data_in  out  CPU_DATA_WIDTH  Register write data.
- cpu_data_out  in  CPU_DATA_WIDTH  Register read data.

Behaviour:
- Reset values: state IDLE; all cpu_* outputs 0; s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata 0; last-grant flag = READ, so the first contended grant goes to WRITE.
- Ready signals are combinational, asserted only in IDLE for the granted type, and forced 0 while reset is low.
- Address mapping: word address = addr[CPU_ADDR_WIDTH+1:2]. Bits [1:0] and bits above CPU_ADDR_WIDTH+1 are ignored, so accesses alias.
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- Write request exists only when s_awvalid && s_wvalid. AW alone or W alone is never accepted.
- Read request exists when s_arvalid.
- IDLE, both requests pending: grant the type opposite to the last grant. One request pending: grant it. Update the last-grant flag on every grant.
- Write path (handshake in cycle 0):
  - Cycle 0: s_awready = s_wready = 1. Capture address, data and strobe-full flag; go to WR_ISSUE.
  - Cycle 1 (WR_ISSUE): cpu_wr_addr and cpu_data_in already carry the captured values.
  - cpu_wr = 1 for exactly cycle 1, and only if s_wstrb was all-ones.
  - s_bresp = 00 if strobes were full, else 10 with no cpu_wr.
  - Cycle 2 onward (WR_RESP): s_bvalid = 1, held until s_bready, then return to IDLE.
- Read path (handshake in cycle 0):
  - Cycle 0: s_arready = 1. cpu_wr_addr updates at the end of cycle 0.
  - Cycle 1 (RD_ISSUE): cpu_rd = 1 for exactly cycle 1.
  - RD_WAIT: a 3-bit counter runs so that cpu_data_out is captured into s_rdata on the edge ending cycle 1+RD_LAT.
  - Cycle 2+RD_LAT onward (RD_RESP): s_rvalid = 1, s_rresp = 00, s_rdata stable, held until s_rready, then return to IDLE.
- cpu_wr_addr and cpu_data_in hold their last values in IDLE and change only on a grant.
- While a B or R response is pending, no new transaction is accepted: all readies stay 0.
- Reset asserted mid-transaction: the transaction is dropped, every output returns to its reset value immediately, and no response is ever issued for it.
- With s_bready/s_rready held high, back-to-back throughput is one write per 3 cycles and one read per 3+RD_LAT cycles.

Test Plan:
- Write s_awaddr=0x20, s_wdata=0x0000_1234, s_wstrb=0xF -> cpu_wr high exactly 1 cycle with cpu_wr_addr=0x008 and cpu_data_in=0x1234; s_bvalid in cycle 2; s_bresp=00.
- Read s_araddr=0x0, register model returning registered data 0x2018_0702 at word 0 -> cpu_rd high 1 cycle; s_rvalid first in cycle 4 (RD_LAT=2); s_rdata=0x2018_0702; s_rresp=00.
- Write with s_wstrb=0x3 to 0x18 -> no cpu_wr pulse; s_bresp=10; register value unchanged on read-back.
- After reset, AW+W and AR asserted in the same cycle, held for 4 transactions -> grant order is W, R, W, R. Also: s_awvalid without s_wvalid never gets s_awready while a pending read completes.
- Hold s_bready=0 for 5 cycles after a write while s_arvalid=1 -> s_bvalid stays 1 and s_arready stays 0 until the B handshake; the read is accepted in the cycle after it.
- Drive reset low during RD_WAIT -> s_rvalid never asserts and all outputs are 0. After release, a read of 0x4 completes normally with correct data.
